// File: rtl/div.sv
// div: iterative 32-bit signed/unsigned restoring divider returning {remainder, quotient}
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);
   typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;
   state_t      state_q, state_d;
   logic [64:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        sgn_q, sgn_d, s1_q, s1_d, s2_q, s2_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;
   logic [32:0] t;
   logic [31:0] abs1, abs2, quot, rem;
   assign t    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
   assign abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
   assign quot = (sgn_q && (s1_q ^ s2_q)) ? -dividend_q[31:0] : dividend_q[31:0];
   assign rem  = (sgn_q && s1_q) ? -dividend_q[64:33] : dividend_q[64:33];
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      cnt_d      = cnt_q;
      sgn_d      = sgn_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      result_d   = result_q;
      ready_d    = ready_q;
      case (state_q)
         DivFree: begin
            ready_d  = 1'b0;
            result_d = 64'd0;
            if (start_i && !annul_i) begin
               state_d    = (opdata2_i == 32'd0) ? DivByZero : DivOn;
               cnt_d      = 6'd0;
               dividend_d = {32'd0, abs1, 1'b0};
               divisor_d  = abs2;
               sgn_d      = signed_div_i;
               s1_d       = opdata1_i[31];
               s2_d       = opdata2_i[31];
            end
         end
         DivByZero: begin
            dividend_d = 65'd0;
            state_d    = DivEnd;
         end
         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
            end else if (cnt_q != 6'd32) begin
               dividend_d = t[32] ? {dividend_q[63:0], 1'b0} : {t[31:0], dividend_q[31:0], 1'b1};
               cnt_d      = cnt_q + 6'd1;
            end else begin
               // sign correction is folded back into the dividend register
               dividend_d = {rem, dividend_q[32], quot};
               state_d    = DivEnd;
            end
         end
         DivEnd: begin
            result_d = start_i ? {dividend_q[64:33], dividend_q[31:0]} : 64'd0;
            ready_d  = start_i;
            state_d  = start_i ? DivEnd : DivFree;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DivFree;
         dividend_q <= 65'd0;
         divisor_q  <= 32'd0;
         cnt_q      <= 6'd0;
         sgn_q      <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         result_q   <= 64'd0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         cnt_q      <= cnt_d;
         sgn_q      <= sgn_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end
   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign stallreq_o = start_i & ~ready_q & ~annul_i;
endmodule

// File: tb/tb_div.sv
// tb_div: directed and randomized checks of div against an arithmetic reference model
module tb_div;
   logic        clk = 1'b0;
   logic        rst, signed_div_i, start_i, annul_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o, stallreq_o;
   int          total = 0, bad = 0;
   div dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
      .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
      end else begin
         q = longint'({32'd0, a}) / longint'({32'd0, b});
         r = longint'({32'd0, a}) % longint'({32'd0, b});
      end
      return {r[31:0], q[31:0]};
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // called at a negedge; returns at a negedge with the handshake completed
   task automatic divide(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input logic ann_end);
      int n, stalls;
      logic [63:0] got;
      signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
      n = 0; stalls = 0;
      do begin
         #1;
         if (stallreq_o) stalls++;
         @(posedge clk); n++;
         @(negedge clk);
         if (n == 3) begin
            opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
         end
      end while (!ready_o && n < 100);
      chk("latency", 64'(n - 1), (b == 32'd0) ? 64'd2 : 64'd34);
      chk("stall_cycles", 64'(stalls), (b == 32'd0) ? 64'd3 : 64'd35);
      chk("result", result_o, exp);
      got = result_o;
      for (int i = 0; i < hold; i++) begin
         annul_i = ann_end;
         @(posedge clk); @(negedge clk);
         chk("hold_ready", 64'(ready_o), 64'd1);
         chk("hold_result", result_o, got);
         if (ann_end) chk("hold_stall", 64'(stallreq_o), 64'd0);
      end
      annul_i = 1'b0; start_i = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("drop_ready", 64'(ready_o), 64'd0);
      chk("drop_result", result_o, 64'd0);
   endtask
   initial begin
      logic        s, seen;
      logic [31:0] a, b;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'd0; opdata2_i = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_stall", 64'(stallreq_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      divide(1'b0, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 5, 1'b0);
      divide(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 0, 1'b0);
      divide(1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 2, 1'b1);
      divide(1'b0, 32'h12345678, 32'h00000000, 64'h0, 1, 1'b0);
      divide(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 1'b0);
      // start together with annul while idle is never accepted
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
      start_i = 1'b1; annul_i = 1'b1;
      #1 chk("annul_free_stall", 64'(stallreq_o), 64'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         seen |= ready_o;
      end
      start_i = 1'b0; annul_i = 1'b0;
      repeat (40) begin
         @(posedge clk); @(negedge clk);
         seen |= ready_o;
      end
      chk("annul_free_ready", 64'(seen), 64'd0);
      // annul at iteration 10
      opdata1_i = 32'h00ABCDEF; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (10) begin
         @(posedge clk); @(negedge clk);
      end
      annul_i = 1'b1;
      #1 chk("annul_on_stall", 64'(stallreq_o), 64'd0);
      @(posedge clk); @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); @(negedge clk);
         seen |= ready_o;
      end
      chk("annul_on_ready", 64'(seen), 64'd0);
      divide(1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 0, 1'b0);
      // synchronous reset at iteration 20
      opdata1_i = 32'h7654321F; opdata2_i = 32'd9; start_i = 1'b1;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b1; start_i = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_mid_ready", 64'(ready_o), 64'd0);
      chk("rst_mid_result", result_o, 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); @(negedge clk);
         seen |= ready_o;
      end
      chk("rst_mid_noresult", 64'(seen), 64'd0);
      for (int k = 0; k < 25; k++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = -$urandom_range(1, 15);
            default: b = $urandom;
         endcase
         divide(s, a, b, model(s, a, b), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div.md
# div

- Iterative 32-bit signed/unsigned divider for the execute stage.
- Accepts operands from EX under a start/ready handshake and computes one quotient bit per cycle (restoring algorithm).
- Returns `{remainder, quotient}` as a 64-bit word for HI/LO write-back.
- While a division is in flight it drives the EX stall request. The controller turns this request into `stall[5:0]`, which freezes the PC, IF/ID and ID/EX registers and inserts bubbles into EX/MEM.

## Interface
Parameters:
- none (widths come from the shared defines: `RegBus` = 32 bits, `DoubleRegBus` = 64 bits)

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset; synchronous and active-high (`RstEnable` = 1).
- `signed_div_i`  in  1  — 1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  — dividend.
- `opdata2_i`  in  32  — divisor.
- `start_i`  in  1  — request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  — cancel the in-flight division (flush or exception).
- `result_o`  out  64  — `{remainder[31:0], quotient[31:0]}`.
- `ready_o`  out  1  — result valid; registered.
- `stallreq_o`  out  1  — combinational: `start_i & ~ready_o & ~annul_i`.

## Operation
State register has four states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`. Internal registers:
- `dividend` (65 bits)
- `divisor` (32 bits)
- `cnt` (6 bits)
- latched sign info: signed flag, `op1[31]`, `op2[31]`

**DivFree**
- If `start_i=1` and `annul_i=0`:
  - divisor == 0 → go to `DivByZero`.
  - otherwise → go to `DivOn`.
    - `cnt` ← 0.
    - In signed mode, negative operands are replaced by their two's complement.
    - `dividend` ← `{32'b0, |op1|, 1'b0}`, `divisor` ← `|op2|`.
    - Latch the sign info.
- Otherwise stay in `DivFree`; `ready_o`=0 and `result_o`=0.

**DivByZero**
- `dividend` ← 0, then go to `DivEnd`.
- Final result is 0 in both halves.

**DivOn**
- `annul_i=1` → go to `DivFree` immediately; `ready_o` stays 0.
- Iteration, while `cnt != 32`:
  - `t = {1'b0, dividend[63:32]} - {1'b0, divisor}`.
  - If `t[32]=1` (negative): `dividend` ← `{dividend[63:0], 1'b0}`.
  - Else: `dividend` ← `{t[31:0], dividend[31:0], 1'b1}`.
  - `cnt` ← `cnt+1`.
- Finalize, when `cnt == 32`:
  - Quotient = `dividend[31:0]`, negated if signed and `op1[31]^op2[31]`.
  - Remainder = `dividend[64:33]`, negated if signed and `op1[31]`.
  - Go to `DivEnd`.

**DivEnd**
- `result_o` ← `{rem, quot}` and `ready_o` ← 1.
- When `start_i=0` → go to `DivFree`; clear `ready_o` and `result_o` to 0.

Arithmetic rules:
- All math is modulo 2^32.
- `0x80000000 / 0xFFFFFFFF` (signed) gives quotient `0x80000000`, remainder 0; no trap.

Inputs are sampled only in `DivFree`. Changes to the operand inputs mid-operation are ignored.

## Timing
- Reset: on any `clk` edge with `rst=1`:
  - state ← `DivFree`, `ready_o` ← 0, `result_o` ← 0, `cnt` ← 0.
  - This overrides any in-flight division.
- Latency, with the start accepted at edge E0:
  - Iterations happen at E1–E32.
  - Finalize happens at E33.
  - `ready_o`=1 and `result_o` are valid after E34.
  - `stallreq_o` is high from the cycle `start_i` rises through the cycle before `ready_o`, which is 35 cycles of stall.
- Divide-by-zero: E0 → `DivByZero`, E1 → `DivEnd`, and `ready_o`=1 after E2.
- `ready_o` stays high, with `result_o` stable, for every cycle that `start_i` remains high.
  - It drops on the edge after `start_i` falls.
  - A new start is accepted no earlier than the edge after that.
- `annul_i` in `DivFree`: the start is not accepted.
- `annul_i` in `DivEnd`: no effect; the handshake still completes on the fall of `start_i`.
- Simultaneous `start_i` and `annul_i`: annul wins; `stallreq_o`=0.

## Test plan
- Unsigned `0x00000064 / 0x00000007`:
  - `ready_o` rises exactly 34 edges after the start edge.
  - `result_o` = `0x00000002_0000000E`.
  - `stallreq_o` is high for 35 cycles.
- Signed `-7 / 2` (`0xFFFFFFF9`, `0x00000002`):
  - `result_o` = `0xFFFFFFFF_FFFFFFFD`.
  - The same operands with `signed_div_i=0` give `0x00000001_7FFFFFFC`.
- Divisor 0 (`0x12345678 / 0`): `ready_o` after 2 edges, `result_o` = 0; the stall lasts 3 cycles.
- Annul at iteration 10:
  - State returns to `DivFree`; `ready_o` never rises.
  - A following `0xFFFFFFFF / 0x00000010` (unsigned) yields `0x0000000F_0FFFFFFF`.
- Sync reset asserted at iteration 20: all outputs are 0 on the next edge; no result appears after `rst` is released.
- Handshake: hold `start_i` 5 cycles past `ready_o`.
  - `result_o` stays stable throughout.
  - `ready_o` clears one edge after `start_i` falls.
  - A back-to-back start is accepted on the following edge.
